mmio_bus_interconnect: RTL and testbench
========================================

Name: mmio_bus_interconnect

Overview:
- Parametrised single-master, multi-slave MMIO interconnect between the multicycle CPU memory port and N memory-mapped peripherals (BRAM, GPIO, future SPI flash/UART).
- Replaces the fixed two-region decode and delayed-address read mux with a registered request/acknowledge handshake.
- Adds variable-latency slaves, unmapped-address error responses, a per-transaction timeout, and error logging.

Parameters:
- NUM_SLAVES, 4, number of slave ports.
- ADDR_W, 32, address width.
- DATA_W, 32, data width; must be a multiple of 8.
- SLAVE_BASE, {32'hFFFF_FFF0, 32'h0000_0800, 32'h0000_0000, ...}, packed NUM_SLAVES*ADDR_W; inclusive base address of slave k at bits [k*ADDR_W +: ADDR_W].
- SLAVE_LAST, packed NUM_SLAVES*ADDR_W, inclusive last address of slave k.
- TIMEOUT_CYCLES, 16, number of BUSY cycles without ack before abort; range 1..65535.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- m_req  in  1  master request; sampled only in IDLE
- m_addr  in  ADDR_W  master address
- m_wdata  in  DATA_W  master write data
- m_we  in  1  1=write, 0=read
- m_be  in  DATA_W/8  byte mask
- m_ready  out  1  one-cycle completion pulse
- m_rdata  out  DATA_W  registered read data; valid when m_ready=1
- m_err  out  1  valid with m_ready; 1 = unmapped address or timeout
- s_req  out  NUM_SLAVES  one-hot request, held until ack or abort
- s_addr  out  ADDR_W  latched address, broadcast to all slaves
- s_wdata  out  DATA_W  latched write data, broadcast
- s_we  out  1  latched write enable
- s_be  out  DATA_W/8  latched byte mask
- s_ack  in  NUM_SLAVES  slave completion; s_rdata valid in the same cycle
- s_rdata  in  NUM_SLAVES*DATA_W  slave k read data at bits [k*DATA_W +: DATA_W]
- err_addr  out  ADDR_W  address of the most recent errored transaction
- err_count  out  16  saturating count of errored transactions

Behaviour:
- Reset values: all outputs 0, state IDLE, timeout counter 0. Reset mid-transaction deasserts s_req on that edge; m_ready does not fire for the aborted transaction.
- States: IDLE, BUSY, RESP.
- IDLE, m_req=1:
  - Decode m_addr against SLAVE_BASE <= addr <= SLAVE_LAST, unsigned compare. On overlapping regions, the lowest index wins.
  - Latch addr, wdata, we and be into the s_* registers.
  - Hit slave k: sel<=k, s_req[k]<=1, go to BUSY.
  - Miss: latch the error, go to RESP.
- BUSY:
  - s_req[sel] and all s_* signals stay stable.
  - s_ack[sel]=1: on a read, m_rdata<=s_rdata[sel]; on a write, m_rdata keeps its prior value. Then s_req<=0, go to RESP, m_err<=0.
  - Acks from unselected slaves are ignored.
  - Timeout counter counts BUSY cycles. If it reaches TIMEOUT_CYCLES with no ack: s_req<=0, m_rdata<=0, error path, go to RESP.
  - An ack arriving in the same cycle the counter would expire takes priority over the timeout.
- RESP: m_ready=1 for exactly one cycle, m_err as set, then go to IDLE. m_req is ignored in RESP and BUSY.
- Error path: err_addr<=latched address; err_count+1, saturating at 16'hFFFF. An unmapped read returns m_rdata=0.
- Latency: m_req sampled at edge 0; s_req high after edge 0. A slave acking in its first BUSY cycle gives m_ready high after edge 2. An unmapped address gives m_ready after edge 1.
- Back-to-back: a new request can be accepted on the edge following the m_ready cycle.

Test Plan:
- BRAM read: addr 0x0000_0004, slave 0 acks in the 1st BUSY cycle with 0x1234_5678 -> s_req=0001 for 1 cycle; m_ready 2 cycles after the request with m_rdata=0x1234_5678, m_err=0.
- GPIO write with wait states: addr 0xFFFF_FFF0, wdata 0x3, be 0001, ack after 3 cycles -> s_req[3] held 3 cycles with s_addr/s_wdata/s_be stable; m_ready with m_err=0; m_rdata unchanged.
- Unmapped read: addr 0x8000_0000 -> no s_req; m_ready 1 cycle after the request, m_err=1, m_rdata=0, err_addr=0x8000_0000, err_count=1.
- Timeout: slave never acks, TIMEOUT_CYCLES=16 -> s_req drops after 16 BUSY cycles; m_ready with m_err=1, err_count increments.
- Spurious ack: slave 1 acks while slave 0 is selected -> ignored; completion waits for s_ack[0]. Ack on the timeout-expiry cycle -> m_err=0.
- Reset at BUSY cycle 2 -> s_req=0 on the next edge, no m_ready. err_count saturation: preload 0xFFFF, then an error -> stays 0xFFFF.

Source files
------------

// File: rtl/mmio_bus_interconnect.sv
// mmio_bus_interconnect: single-master, multi-slave MMIO interconnect with request/ack handshake, timeout and error logging
module mmio_bus_interconnect #(
  parameter int NUM_SLAVES = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_BASE = {32'hFFFF_FFF0, 32'h0000_0800, 32'h0000_0000, 32'h0000_0000},
  parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_LAST = {32'hFFFF_FFFF, 32'h0000_0FFF, 32'h0000_0BFF, 32'h0000_07FF},
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         m_req,
  input  logic [ADDR_W-1:0]            m_addr,
  input  logic [DATA_W-1:0]            m_wdata,
  input  logic                         m_we,
  input  logic [DATA_W/8-1:0]          m_be,
  output logic                         m_ready,
  output logic [DATA_W-1:0]            m_rdata,
  output logic                         m_err,
  output logic [NUM_SLAVES-1:0]        s_req,
  output logic [ADDR_W-1:0]            s_addr,
  output logic [DATA_W-1:0]            s_wdata,
  output logic                         s_we,
  output logic [DATA_W/8-1:0]          s_be,
  input  logic [NUM_SLAVES-1:0]        s_ack,
  input  logic [NUM_SLAVES*DATA_W-1:0] s_rdata,
  output logic [ADDR_W-1:0]            err_addr,
  output logic [15:0]                  err_count
);
  localparam int SW = NUM_SLAVES > 1 ? $clog2(NUM_SLAVES) : 1;
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  state_t state;
  logic [SW-1:0] sel, hit_idx;
  logic hit, sel_ack;
  logic [15:0] cnt, err_next;
  logic [DATA_W-1:0] sel_rdata;
  assign sel_ack = s_ack[sel];
  assign sel_rdata = s_rdata[sel*DATA_W +: DATA_W];
  assign err_next = err_count + {15'd0, ~&err_count};
  always_comb begin
    hit = 1'b0;
    hit_idx = '0;
    for (int k = NUM_SLAVES - 1; k >= 0; k--)
      if (m_addr >= SLAVE_BASE[k*ADDR_W +: ADDR_W] && m_addr <= SLAVE_LAST[k*ADDR_W +: ADDR_W]) begin
        hit = 1'b1;
        hit_idx = SW'(k);
      end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      sel <= '0;
      cnt <= '0;
      m_ready <= 1'b0;
      m_rdata <= '0;
      m_err <= 1'b0;
      s_req <= '0;
      s_addr <= '0;
      s_wdata <= '0;
      s_we <= 1'b0;
      s_be <= '0;
      err_addr <= '0;
      err_count <= '0;
    end else begin
      m_ready <= 1'b0;
      case (state)
        IDLE: if (m_req) begin
          s_addr <= m_addr;
          s_wdata <= m_wdata;
          s_we <= m_we;
          s_be <= m_be;
          if (hit) begin
            sel <= hit_idx;
            s_req <= NUM_SLAVES'(1) << hit_idx;
            cnt <= '0;
            state <= BUSY;
          end else begin
            m_err <= 1'b1;
            m_rdata <= '0;
            err_addr <= m_addr;
            err_count <= err_next;
            state <= RESP;
          end
        end
        BUSY: if (sel_ack) begin
          m_rdata <= s_we ? m_rdata : sel_rdata;
          m_err <= 1'b0;
          s_req <= '0;
          state <= RESP;
        end else if (cnt == 16'(TIMEOUT_CYCLES - 1)) begin
          s_req <= '0;
          m_rdata <= '0;
          m_err <= 1'b1;
          err_addr <= s_addr;
          err_count <= err_next;
          state <= RESP;
        end else begin
          cnt <= cnt + 16'd1;
        end
        RESP: begin
          m_ready <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mmio_bus_interconnect.sv
// tb_mmio_bus_interconnect: directed self-checking bench for mmio_bus_interconnect
module tb_mmio_bus_interconnect;
  logic clk = 1'b0;
  logic reset;
  logic m_req;
  logic [31:0] m_addr, m_wdata, m_rdata, s_addr, s_wdata, err_addr;
  logic m_we, m_ready, m_err, s_we;
  logic [3:0] m_be, s_be, s_req, s_ack;
  logic [127:0] s_rdata;
  logic [15:0] err_count;
  int checks = 0;
  int failures = 0;
  mmio_bus_interconnect dut (
    .clk(clk), .reset(reset), .m_req(m_req), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_we(m_we), .m_be(m_be), .m_ready(m_ready), .m_rdata(m_rdata), .m_err(m_err),
    .s_req(s_req), .s_addr(s_addr), .s_wdata(s_wdata), .s_we(s_we), .s_be(s_be),
    .s_ack(s_ack), .s_rdata(s_rdata), .err_addr(err_addr), .err_count(err_count)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  initial begin
    reset = 1'b1;
    m_req = 1'b0;
    m_addr = '0;
    m_wdata = '0;
    m_we = 1'b0;
    m_be = '0;
    s_ack = '0;
    s_rdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_m_ready", 32'(m_ready), 32'd0);
    chk("rst_s_req", 32'(s_req), 32'd0);
    chk("rst_m_rdata", m_rdata, 32'd0);
    chk("rst_m_err", 32'(m_err), 32'd0);
    chk("rst_err_count", 32'(err_count), 32'd0);
    chk("rst_err_addr", err_addr, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    m_req = 1'b1; m_addr = 32'h0000_0004; m_we = 1'b0; m_be = 4'hF;
    @(negedge clk);
    chk("rd_s_req", 32'(s_req), 32'h1);
    chk("rd_s_addr", s_addr, 32'h4);
    chk("rd_ready_early", 32'(m_ready), 32'd0);
    m_req = 1'b0; s_ack = 4'b0001; s_rdata[31:0] = 32'h1234_5678;
    @(negedge clk);
    chk("rd_s_req_drop", 32'(s_req), 32'd0);
    chk("rd_ready_e1", 32'(m_ready), 32'd0);
    s_ack = '0;
    @(negedge clk);
    chk("rd_ready", 32'(m_ready), 32'd1);
    chk("rd_rdata", m_rdata, 32'h1234_5678);
    chk("rd_err", 32'(m_err), 32'd0);
    m_req = 1'b1; m_addr = 32'hFFFF_FFF0; m_wdata = 32'h3; m_we = 1'b1; m_be = 4'b0001;
    @(negedge clk);
    chk("wr_ready_pulse", 32'(m_ready), 32'd0);
    chk("wr_s_req_c1", 32'(s_req), 32'h8);
    m_req = 1'b0; m_addr = 32'hDEAD_BEEF; m_wdata = 32'h5555_AAAA; m_we = 1'b0; m_be = 4'hF;
    s_rdata[127:96] = 32'hAAAA_5555;
    @(negedge clk);
    chk("wr_s_req_c2", 32'(s_req), 32'h8);
    chk("wr_s_addr", s_addr, 32'hFFFF_FFF0);
    chk("wr_s_wdata", s_wdata, 32'h3);
    chk("wr_s_be", 32'(s_be), 32'h1);
    chk("wr_s_we", 32'(s_we), 32'd1);
    @(negedge clk);
    chk("wr_s_req_c3", 32'(s_req), 32'h8);
    chk("wr_s_addr_c3", s_addr, 32'hFFFF_FFF0);
    s_ack = 4'b1000;
    @(negedge clk);
    chk("wr_s_req_drop", 32'(s_req), 32'd0);
    s_ack = '0;
    @(negedge clk);
    chk("wr_ready", 32'(m_ready), 32'd1);
    chk("wr_err", 32'(m_err), 32'd0);
    chk("wr_rdata_kept", m_rdata, 32'h1234_5678);
    m_req = 1'b1; m_addr = 32'h8000_0000; m_we = 1'b0;
    @(negedge clk);
    chk("um_s_req", 32'(s_req), 32'd0);
    chk("um_ready_early", 32'(m_ready), 32'd0);
    m_req = 1'b0;
    @(negedge clk);
    chk("um_ready", 32'(m_ready), 32'd1);
    chk("um_err", 32'(m_err), 32'd1);
    chk("um_rdata", m_rdata, 32'd0);
    chk("um_err_addr", err_addr, 32'h8000_0000);
    chk("um_err_count", 32'(err_count), 32'd1);
    @(negedge clk);
    chk("um_ready_pulse", 32'(m_ready), 32'd0);
    m_req = 1'b1; m_addr = 32'h0000_0900; m_we = 1'b0;
    @(negedge clk);
    chk("to_s_req", 32'(s_req), 32'h2);
    m_req = 1'b0;
    repeat (15) @(negedge clk);
    chk("to_s_req_c16", 32'(s_req), 32'h2);
    @(negedge clk);
    chk("to_s_req_drop", 32'(s_req), 32'd0);
    chk("to_ready_early", 32'(m_ready), 32'd0);
    @(negedge clk);
    chk("to_ready", 32'(m_ready), 32'd1);
    chk("to_err", 32'(m_err), 32'd1);
    chk("to_rdata", m_rdata, 32'd0);
    chk("to_err_count", 32'(err_count), 32'd2);
    chk("to_err_addr", err_addr, 32'h0000_0900);
    m_req = 1'b1; m_addr = 32'h0000_0010; m_we = 1'b0;
    @(negedge clk);
    chk("sp_s_req", 32'(s_req), 32'h1);
    m_req = 1'b0; s_ack = 4'b0010; s_rdata[63:32] = 32'hBAD0_BAD0;
    repeat (15) @(negedge clk);
    chk("sp_ignored", 32'(s_req), 32'h1);
    chk("sp_no_ready", 32'(m_ready), 32'd0);
    s_ack = 4'b0011; s_rdata[31:0] = 32'hCAFE_BABE;
    @(negedge clk);
    chk("sp_s_req_drop", 32'(s_req), 32'd0);
    s_ack = '0;
    @(negedge clk);
    chk("sp_ready", 32'(m_ready), 32'd1);
    chk("sp_err", 32'(m_err), 32'd0);
    chk("sp_rdata", m_rdata, 32'hCAFE_BABE);
    chk("sp_err_count", 32'(err_count), 32'd2);
    m_req = 1'b1; m_addr = 32'h0000_0004; m_we = 1'b0;
    @(negedge clk);
    chk("rs_s_req", 32'(s_req), 32'h1);
    m_req = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("rs_s_req_drop", 32'(s_req), 32'd0);
    chk("rs_no_ready", 32'(m_ready), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("rs_no_ready2", 32'(m_ready), 32'd0);
    chk("rs_err_count", 32'(err_count), 32'd0);
    force dut.err_count = 16'hFFFF;
    @(negedge clk);
    release dut.err_count;
    m_req = 1'b1; m_addr = 32'h4000_0000; m_we = 1'b1;
    @(negedge clk);
    m_req = 1'b0;
    @(negedge clk);
    chk("sat_ready", 32'(m_ready), 32'd1);
    chk("sat_err", 32'(m_err), 32'd1);
    chk("sat_err_count", 32'(err_count), 32'h0000_FFFF);
    chk("sat_err_addr", err_addr, 32'h4000_0000);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
